metronome_core: RTL

//  Parametrised successor to the fixed 2-LED metronome datapath: BPM control, beat generation, bar/accent tracking.

---
 rtl/metronome_pkg.sv | 22 ++
 rtl/metronome_btn_event.sv | 59 +++++
 rtl/metronome_core.sv | 118 +++++++++++
 3 files changed

// File: rtl/metronome_pkg.sv
// Shared types and helpers for the metronome datapath.
package metronome_pkg;

    localparam int BPM_W_DEF = 8;

    typedef logic [BPM_W_DEF-1:0] bpm_t;

    // Accumulator units per beat: one beat per minute at bpm=1.
    function automatic longint beat_thresh(input longint clk_hz);
        return 60 * clk_hz;
    endfunction

    function automatic int clamp_bar(input int bpb, input int num_leds);
        if (bpb < 1)
            return 1;
        else if (bpb > num_leds)
            return num_leds;
        else
            return bpb;
    endfunction

endpackage

// File: rtl/metronome_btn_event.sv
// Button synchroniser + rising-edge event; METRONOME_AUTOREPEAT_EN adds hold-to-repeat.
module metronome_btn_event
    import metronome_pkg::*;
`ifdef METRONOME_AUTOREPEAT_EN
#(
    parameter int CLK_HZ = 50_000_000
)
`endif
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_evt
);

    logic r_s1, r_s2, r_s3;
    logic w_rise;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

`ifdef METRONOME_AUTOREPEAT_EN
    localparam int HOLD_CYC = CLK_HZ / 2;
    localparam int RPT_CYC  = CLK_HZ / 10;
    localparam int CNT_W    = $clog2(HOLD_CYC + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_rpt;

    assign w_rpt = r_s2 && (r_cnt == CNT_W'(HOLD_CYC));

    // Counter measures hold time from the press; after the first repeat it
    // is rewound so the next one lands RPT_CYC later.
    always_ff @(posedge i_clk) begin
        if (i_rst || !r_s2)
            r_cnt <= '0;
        else if (w_rpt)
            r_cnt <= CNT_W'(HOLD_CYC - RPT_CYC);
        else
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_evt = w_rise | w_rpt;
`else
    assign o_evt = w_rise;
`endif

endmodule

// File: rtl/metronome_core.sv
// Metronome core: BPM register, phase accumulator, beat/bar tracking, LED decode.
// Optional build macro: METRONOME_AUTOREPEAT_EN (button hold-to-repeat).
module metronome_core
    import metronome_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BPM_W     = 8,
    parameter int BPM_MIN   = 30,
    parameter int BPM_MAX   = 250,
    parameter int BPM_STEP  = 10,
    parameter int BPM_RESET = 120,
    parameter int NUM_LEDS  = 4,
    localparam int BB_W     = $clog2(NUM_LEDS + 1),
    localparam int IDX_W    = $clog2(NUM_LEDS)
)(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_btn_dec,
    input  logic                i_btn_inc,
    input  logic                i_run,
    input  logic [BB_W-1:0]     i_beats_per_bar,
    output logic [BPM_W-1:0]    o_bpm,
    output logic                o_beat_pulse,
    output logic                o_accent_pulse,
    output logic [IDX_W-1:0]    o_beat_idx,
    output logic [NUM_LEDS-1:0] o_led
);

    localparam longint THRESH_L = beat_thresh(longint'(CLK_HZ));
    localparam int     ACC_W    = $clog2(THRESH_L + longint'(2**BPM_W));
    localparam logic [ACC_W-1:0] THRESH = ACC_W'(THRESH_L);

    logic                w_inc_evt, w_dec_evt;
    logic [BPM_W-1:0]    r_bpm, w_bpm_nxt;
    logic [BPM_W:0]      w_bpm_up;
    logic [ACC_W-1:0]    r_acc, w_sum;
    logic                w_fire;
    logic                r_started;
    logic [BB_W-1:0]     r_bar_len, w_bar_req, w_idx_inc;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt, w_led_idx;
    logic                r_beat, r_accent;
    logic [NUM_LEDS-1:0] r_led;

    metronome_btn_event
`ifdef METRONOME_AUTOREPEAT_EN
        #(.CLK_HZ(CLK_HZ))
`endif
        u_btn_inc (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_inc), .o_evt(w_inc_evt));

    metronome_btn_event
`ifdef METRONOME_AUTOREPEAT_EN
        #(.CLK_HZ(CLK_HZ))
`endif
        u_btn_dec (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_dec), .o_evt(w_dec_evt));

    assign w_bpm_up = {1'b0, r_bpm} + (BPM_W+1)'(BPM_STEP);

    // Saturating step; opposing events in the same cycle cancel.
    always_comb begin
        w_bpm_nxt = r_bpm;
        if (w_inc_evt && !w_dec_evt)
            w_bpm_nxt = (w_bpm_up > (BPM_W+1)'(BPM_MAX)) ? BPM_W'(BPM_MAX) : w_bpm_up[BPM_W-1:0];
        else if (w_dec_evt && !w_inc_evt)
            w_bpm_nxt = ({1'b0, r_bpm} < (BPM_W+1)'(BPM_MIN + BPM_STEP)) ?
                        BPM_W'(BPM_MIN) : r_bpm - BPM_W'(BPM_STEP);
    end

    assign w_sum     = r_acc + ACC_W'(r_bpm);
    assign w_fire    = (w_sum >= THRESH);
    assign w_bar_req = BB_W'(clamp_bar(int'(i_beats_per_bar), NUM_LEDS));
    assign w_idx_inc = BB_W'(r_idx) + BB_W'(1);

    // The first beat after run rises starts a fresh bar rather than advancing.
    assign w_idx_nxt = (!r_started || (w_idx_inc == r_bar_len)) ? '0 : w_idx_inc[IDX_W-1:0];
    assign w_led_idx = w_fire ? w_idx_nxt : r_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bpm     <= BPM_W'(BPM_RESET);
            r_acc     <= '0;
            r_idx     <= '0;
            r_started <= 1'b0;
            r_beat    <= 1'b0;
            r_accent  <= 1'b0;
            r_led     <= '0;
            r_bar_len <= w_bar_req;
        end else begin
            r_bpm <= w_bpm_nxt;
            if (!i_run) begin
                r_acc     <= '0;
                r_idx     <= '0;
                r_started <= 1'b0;
                r_beat    <= 1'b0;
                r_accent  <= 1'b0;
                r_led     <= '0;
            end else begin
                r_acc    <= w_fire ? (w_sum - THRESH) : w_sum;
                r_beat   <= w_fire;
                r_accent <= w_fire && (w_idx_nxt == '0);
                r_led    <= NUM_LEDS'(1) << w_led_idx;
                if (w_fire) begin
                    r_idx     <= w_idx_nxt;
                    r_started <= 1'b1;
                    // Bar length only changes on a bar boundary.
                    if (w_idx_nxt == '0)
                        r_bar_len <= w_bar_req;
                end
            end
        end
    end

    assign o_bpm          = r_bpm;
    assign o_beat_pulse   = r_beat;
    assign o_accent_pulse = r_accent;
    assign o_beat_idx     = r_idx;
    assign o_led          = r_led;

endmodule
